// File: rtl/vga_2048_pkg.sv
// vga_2048_pkg: 640x480@60 raster constants, tile palette and board type for the 2048 VGA renderer
package vga_2048_pkg;
  localparam int H_VIS = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_VIS = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam logic [23:0] C_BLACK = 24'h000000;
  localparam logic [23:0] C_GRID = 24'hBBADA0;
  localparam logic [23:0] C_OTHER = 24'h3C3A32;
  localparam logic [23:0] C_LOSE = 24'hC00000;
  localparam logic [23:0] C_WIN = 24'h00C000;
  typedef logic [11:0] tablero_t [0:3][0:3];
  function automatic logic [23:0] tile_color(input logic [11:0] v);
    case (v)
      12'd0: return 24'hCDC1B4;
      12'd2: return 24'hEEE4DA;
      12'd4: return 24'hEDE0C8;
      12'd8: return 24'hF2B179;
      12'd16: return 24'hF59563;
      12'd32: return 24'hF67C5F;
      12'd64: return 24'hF65E3B;
      12'd128: return 24'hEDCF72;
      12'd256: return 24'hEDCC61;
      12'd512: return 24'hEDC850;
      12'd1024: return 24'hEDC53F;
      12'd2048: return 24'hEDC22E;
      default: return C_OTHER;
    endcase
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running raster counters with raw active-low syncs, visible flag and frame-start strobe
module vga_timing
  import vga_2048_pkg::*;
#(
  parameter int HV = H_VIS,
  parameter int HF = H_FP,
  parameter int HS = H_SYNC,
  parameter int HB = H_BP,
  parameter int VV = V_VIS,
  parameter int VF = V_FP,
  parameter int VS = V_SYNC,
  parameter int VB = V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] o_hc,
  output logic [9:0] o_vc,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_visible,
  output logic       o_frame_start
);
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  logic [9:0] r_hc, r_vc;
  logic w_hwrap;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hc <= '0;
      r_vc <= '0;
    end else begin
      r_hc <= w_hwrap ? '0 : r_hc + 10'd1;
      if (w_hwrap) r_vc <= (r_vc == 10'(VT - 1)) ? '0 : r_vc + 10'd1;
    end
  end
  always_comb begin
    w_hwrap = r_hc == 10'(HT - 1);
    o_hc = r_hc;
    o_vc = r_vc;
    o_hsync = !(r_hc >= 10'(HV + HF) && r_hc < 10'(HV + HF + HS));
    o_vsync = !(r_vc >= 10'(VV + VF) && r_vc < 10'(VV + VF + VS));
    o_visible = r_hc < 10'(HV) && r_vc < 10'(VV);
    o_frame_start = r_hc == '0 && r_vc == '0;
  end
endmodule

// File: rtl/vga_tablero_2048.sv
// vga_tablero_2048: draws a once-per-frame snapshot of the 4x4 2048 board on VGA
// through a 2-stage pipeline (geometry, then colour) with syncs delayed to match.
module vga_tablero_2048
  import vga_2048_pkg::*;
#(
  parameter int X0 = 120,
  parameter int Y0 = 40,
  parameter int TILE = 100,
  parameter int GAP = 4,
  parameter int HV = H_VIS,
  parameter int HF = H_FP,
  parameter int HS = H_SYNC,
  parameter int HB = H_BP,
  parameter int VV = V_VIS,
  parameter int VF = V_FP,
  parameter int VS = V_SYNC,
  parameter int VB = V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  tablero_t   matriz,
  input  logic       win,
  input  logic       lose,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       frame_start
);
  localparam int HT = HV + HF + HS + HB;
  localparam int BW = 4 * TILE;
  logic [9:0] w_hc, w_vc;
  logic w_hs, w_vs, w_vis, w_fs;
  logic w_in_bx, w_in_by, w_in_rx, w_in_ry, w_grid;
  logic [23:0] w_rgb;
  tablero_t r_snap;
  logic r_win, r_lose;
  logic [7:0] r_xoff, r_yoff;
  logic [2:0] r_xidx, r_yidx;
  logic [1:0] r_col, r_row;
  logic r_board, r_grid, r_ring, r_vis, r_hs, r_vs, r_fs;
  vga_timing #(
    .HV(HV), .HF(HF), .HS(HS), .HB(HB), .VV(VV), .VF(VF), .VS(VS), .VB(VB)
  ) u_timing (
    .clk(clk),
    .rst(rst),
    .o_hc(w_hc),
    .o_vc(w_vc),
    .o_hsync(w_hs),
    .o_vsync(w_vs),
    .o_visible(w_vis),
    .o_frame_start(w_fs)
  );
  assign sync_n = 1'b0;
  always_comb begin
    w_in_bx = w_hc >= 10'(X0) && w_hc < 10'(X0 + BW);
    w_in_by = w_vc >= 10'(Y0) && w_vc < 10'(Y0 + BW);
    w_in_rx = w_hc >= 10'(X0 - 8) && w_hc < 10'(X0 + BW + 8);
    w_in_ry = w_vc >= 10'(Y0 - 8) && w_vc < 10'(Y0 + BW + 8);
    w_grid = r_xoff < 8'(GAP) || r_xoff >= 8'(TILE - GAP) || r_yoff < 8'(GAP) || r_yoff >= 8'(TILE - GAP);
    w_rgb = !r_vis ? C_BLACK :
            r_board ? (r_grid ? C_GRID : tile_color(r_snap[r_row][r_col])) :
            r_ring ? (r_lose ? C_LOSE : r_win ? C_WIN : C_BLACK) : C_BLACK;
  end
  // Offset counters track hc/vc without dividers; they re-align one step before the board edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_xoff <= '0;
      r_xidx <= '0;
      r_yoff <= '0;
      r_yidx <= '0;
    end else begin
      if (w_hc == 10'(X0 - 1)) begin
        r_xoff <= '0;
        r_xidx <= '0;
      end else if (r_xoff == 8'(TILE - 1)) begin
        r_xoff <= '0;
        r_xidx <= r_xidx + 3'd1;
      end else r_xoff <= r_xoff + 8'd1;
      if (w_hc == 10'(HT - 1)) begin
        if (w_vc == 10'(Y0 - 1)) begin
          r_yoff <= '0;
          r_yidx <= '0;
        end else if (r_yoff == 8'(TILE - 1)) begin
          r_yoff <= '0;
          r_yidx <= r_yidx + 3'd1;
        end else r_yoff <= r_yoff + 8'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) r_snap[i][j] <= '0;
      r_win <= 1'b0;
      r_lose <= 1'b0;
    end else if (w_hc == '0 && w_vc == 10'(VV)) begin
      r_snap <= matriz;
      r_win <= win;
      r_lose <= lose;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
      r_board <= 1'b0;
      r_grid <= 1'b0;
      r_ring <= 1'b0;
      r_vis <= 1'b0;
      r_hs <= 1'b1;
      r_vs <= 1'b1;
      r_fs <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank_n <= 1'b0;
      frame_start <= 1'b0;
      {r, g, b} <= '0;
    end else begin
      r_col <= r_xidx[1:0];
      r_row <= r_yidx[1:0];
      r_board <= w_in_bx && w_in_by;
      r_grid <= w_grid;
      r_ring <= w_in_rx && w_in_ry && !(w_in_bx && w_in_by);
      r_vis <= w_vis;
      r_hs <= w_hs;
      r_vs <= w_vs;
      r_fs <= w_fs;
      hsync <= r_hs;
      vsync <= r_vs;
      blank_n <= r_vis;
      frame_start <= r_fs;
      {r, g, b} <= w_rgb;
    end
  end
endmodule

// File: tb/tb_vga_tablero_2048.sv
// tb_vga_tablero_2048: directed checks on a full-size instance (reset, line timing, first-frame pixels)
// and a shrunken-raster instance (frame timing, snapshot, palette, ring, mid-frame reset).
module tb_vga_tablero_2048;
  import vga_2048_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  tablero_t m0, m1;
  logic win0 = 1'b0, lose0 = 1'b0, win1 = 1'b0, lose1 = 1'b0;
  logic h0, v0, bn0, sn0, fs0, h1, v1, bn1, sn1, fs1;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  int edges = 0;
  int total = 0;
  int npass = 0;
  int nfail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) edges <= rst ? edges + 1 : 0;
  vga_tablero_2048 d0 (
    .clk(clk), .rst(rst), .matriz(m0), .win(win0), .lose(lose0),
    .hsync(h0), .vsync(v0), .blank_n(bn0), .sync_n(sn0),
    .r(r0), .g(g0), .b(b0), .frame_start(fs0)
  );
  vga_tablero_2048 #(
    .X0(16), .Y0(8), .TILE(8), .GAP(2),
    .HV(64), .HF(4), .HS(8), .HB(4), .VV(48), .VF(2), .VS(2), .VB(4)
  ) d1 (
    .clk(clk), .rst(rst), .matriz(m1), .win(win1), .lose(lose1),
    .hsync(h1), .vsync(v1), .blank_n(bn1), .sync_n(sn1),
    .r(r1), .g(g1), .b(b1), .frame_start(fs1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic at_edge(input int n);
    while (edges < n) @(negedge clk);
  endtask
  task automatic pix0(input string tag, input int x, input int y, input logic [23:0] exp);
    at_edge(y * 800 + x + 2);
    chk(tag, {r0, g0, b0}, exp);
  endtask
  task automatic pix1(input string tag, input int f, input int x, input int y, input logic [23:0] exp);
    at_edge(f * 4480 + y * 80 + x + 2);
    chk(tag, {r1, g1, b1}, exp);
  endtask
  task automatic rst_vals(input string tag);
    chk({tag, "_d0"}, {h0, v0, bn0, sn0, fs0, r0, g0, b0}, {5'b11000, 24'h0});
    chk({tag, "_d1"}, {h1, v1, bn1, sn1, fs1, r1, g1, b1}, {5'b11000, 24'h0});
  endtask
  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        m0[i][j] = '0;
        m1[i][j] = '0;
      end
    @(negedge clk);
    rst_vals("rst_hold1");
    @(negedge clk);
    @(negedge clk);
    rst_vals("rst_hold3");
    rst = 1'b1;
    at_edge(1);
    chk("fs0_e1", fs0, 0);
    chk("fs1_e1", fs1, 0);
    at_edge(2);
    chk("fs0_e2", fs0, 1);
    chk("fs1_e2", fs1, 1);
    chk("bn0_px0", bn0, 1);
    chk("rgb0_px0", {r0, g0, b0}, 24'h0);
    at_edge(3);
    chk("fs0_e3", fs0, 0);
    at_edge(641); chk("bn0_639", bn0, 1);
    at_edge(642); chk("bn0_640", bn0, 0);
    at_edge(657); chk("hs0_655", h0, 1);
    at_edge(658); chk("hs0_656", h0, 0);
    at_edge(753); chk("hs0_751", h0, 0);
    at_edge(754); chk("hs0_752", h0, 1);
    at_edge(1457); chk("hs0_l1_655", h0, 1);
    at_edge(1458); chk("hs0_l1_656", h0, 0);
    pix0("d0_grid_row", 170, 42, 24'hBBADA0);
    pix0("d0_ring_off", 119, 44, 24'h000000);
    pix0("d0_tile00", 170, 44, 24'hCDC1B4);
    pix0("d0_grid_col", 220, 44, 24'hBBADA0);
    rst = 1'b0;
    m1[1][2] = 12'd2048;
    m1[3][3] = 12'd3;
    win1 = 1'b1;
    lose1 = 1'b1;
    @(negedge clk);
    rst_vals("rst_a");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    at_edge(2);
    chk("fs1_b", fs1, 1);
    chk("vs1_b", v1, 1);
    pix1("f0_tile12_empty", 0, 36, 20, 24'hCDC1B4);
    at_edge(3825); chk("bn1_47", bn1, 1);
    at_edge(3842); chk("bn1_48", bn1, 0);
    at_edge(3922); chk("vs1_49", v1, 1);
    at_edge(4002); chk("vs1_50", v1, 0);
    at_edge(4161); chk("vs1_51", v1, 0);
    at_edge(4162); chk("vs1_52", v1, 1);
    at_edge(4481); chk("fs1_4479", fs1, 0);
    at_edge(4482); chk("fs1_4480", fs1, 1);
    m1[0][0] = 12'd8;
    pix1("f1_ygrid", 1, 20, 9, 24'hBBADA0);
    pix1("f1_ytile", 1, 20, 10, 24'hCDC1B4);
    pix1("f1_tile00_old", 1, 20, 12, 24'hCDC1B4);
    pix1("f1_off5", 1, 21, 12, 24'hCDC1B4);
    pix1("f1_off6", 1, 22, 12, 24'hBBADA0);
    pix1("f1_off7", 1, 23, 12, 24'hBBADA0);
    pix1("f1_col1_off0", 1, 24, 12, 24'hBBADA0);
    pix1("f1_tile01", 1, 26, 12, 24'hCDC1B4);
    pix1("f1_ring_out_l", 1, 7, 18, 24'h000000);
    pix1("f1_ring_l8", 1, 8, 18, 24'hC00000);
    pix1("f1_ring_l4", 1, 12, 18, 24'hC00000);
    pix1("f1_ring_r", 1, 55, 18, 24'hC00000);
    pix1("f1_ring_out_r", 1, 56, 18, 24'h000000);
    lose1 = 1'b0;
    pix1("f1_tile12_2048", 1, 36, 20, 24'hEDC22E);
    pix1("f1_tile33_odd", 1, 44, 36, 24'h3C3A32);
    pix1("f2_tile00_8", 2, 20, 12, 24'hF2B179);
    pix1("f2_ring_win", 2, 12, 18, 24'h00C000);
    pix1("f2_tile12_2048", 2, 36, 20, 24'hEDC22E);
    rst = 1'b0;
    @(negedge clk);
    rst_vals("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    at_edge(1); chk("fs1_r1", fs1, 0);
    at_edge(2); chk("fs1_r2", fs1, 1);
    at_edge(69); chk("hs1_67", h1, 1);
    at_edge(70); chk("hs1_68", h1, 0);
    pix1("r_tile00_cleared", 0, 20, 12, 24'hCDC1B4);
    pix1("r_ring_cleared", 0, 12, 18, 24'h000000);
    pix1("r_tile12_cleared", 0, 36, 20, 24'hCDC1B4);
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule
